// File: rtl/data_mem_disp_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_disp_pkg
// Shared constants for the data-memory / display stage of the MIPS core:
//   - active-low seven-segment glyphs for hex digits 0..F ({dp,g,f,e,d,c,b,a})
//   - SEG_BLANK, the all-segments-off pattern
//   - default RAM depth and scanner refresh divider
//   - hex_glyph(), nibble -> glyph lookup
// No ports (package).
// -----------------------------------------------------------------------------
package data_mem_disp_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_SCAN_DIV    = 50000;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] GLYPH_0 = 8'hC0;
  localparam logic [7:0] GLYPH_1 = 8'hF9;
  localparam logic [7:0] GLYPH_2 = 8'hA4;
  localparam logic [7:0] GLYPH_3 = 8'hB0;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h92;
  localparam logic [7:0] GLYPH_6 = 8'h82;
  localparam logic [7:0] GLYPH_7 = 8'hF8;
  localparam logic [7:0] GLYPH_8 = 8'h80;
  localparam logic [7:0] GLYPH_9 = 8'h90;
  localparam logic [7:0] GLYPH_A = 8'h88;
  localparam logic [7:0] GLYPH_B = 8'h83;
  localparam logic [7:0] GLYPH_C = 8'hC6;
  localparam logic [7:0] GLYPH_D = 8'hA1;
  localparam logic [7:0] GLYPH_E = 8'h86;
  localparam logic [7:0] GLYPH_F = 8'h8E;

  // Decimal point (bit 7) is set in every glyph, so it always stays dark.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
    logic [7:0] glyph;
    case (nibble)
      4'h0:    glyph = GLYPH_0;
      4'h1:    glyph = GLYPH_1;
      4'h2:    glyph = GLYPH_2;
      4'h3:    glyph = GLYPH_3;
      4'h4:    glyph = GLYPH_4;
      4'h5:    glyph = GLYPH_5;
      4'h6:    glyph = GLYPH_6;
      4'h7:    glyph = GLYPH_7;
      4'h8:    glyph = GLYPH_8;
      4'h9:    glyph = GLYPH_9;
      4'hA:    glyph = GLYPH_A;
      4'hB:    glyph = GLYPH_B;
      4'hC:    glyph = GLYPH_C;
      4'hD:    glyph = GLYPH_D;
      4'hE:    glyph = GLYPH_E;
      default: glyph = GLYPH_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/data_mem_disp_seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Multiplexed 8-digit seven-segment scanner. A prescaler divides clk down to
// one digit slot every SCAN_DIV cycles; the digit counter walks 0..7 and the
// matching nibble of disp_reg is decoded to an active-low hex glyph.
// Optional build macro: DISP_BLANK_LEAD_EN -- when defined, digits above the
// highest non-zero nibble are blanked (an all-ones); digit 0 is always lit.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset (digit 0, prescaler 0)
//   disp_reg  in   32-bit value to show, digit 0 = bits [3:0]
//   seg       out  active-low segments {dp,g,f,e,d,c,b,a}
//   an        out  active-low digit enables, one-hot-low
// -----------------------------------------------------------------------------
module seg_scan
  import data_mem_disp_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_reg,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    digit;
  logic [3:0]    nibble;
  logic [7:0]    glyph;
  logic          lit;

  // Prescaler and digit counter advance together; the digit only moves on the
  // prescaler wrap so each slot lasts exactly SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit     <= 3'd0;
    end else if (prescaler == PRESCALE_LAST) begin
      prescaler <= '0;
      digit     <= digit + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign nibble = disp_reg[{digit, 2'b00} +: 4];
  assign glyph  = hex_glyph(nibble);

`ifdef DISP_BLANK_LEAD_EN
  logic [2:0] top_nibble;

  // Index of the most significant non-zero nibble; stays 0 for a zero value
  // so the least significant digit always shows.
  always_comb begin
    top_nibble = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (disp_reg[4*i +: 4] != 4'h0) begin
        top_nibble = 3'(i);
      end
    end
  end

  assign lit = (digit <= top_nibble);
`else
  assign lit = 1'b1;
`endif

  // Decode is combinational from the digit counter and disp_reg, so a display
  // store or a reset is visible on the pins in the cycle after its edge.
  always_comb begin
    an  = 8'hFF;
    seg = SEG_BLANK;
    if (lit) begin
      an  = ~(8'b1 << digit);
      seg = glyph;
    end
  end

endmodule

// File: rtl/data_mem_disp.sv
// -----------------------------------------------------------------------------
// data_mem_disp
// Data-memory stage of the five-stage MIPS core: word-addressed data RAM with
// zero-latency reads plus a memory-mapped display register driving an 8-digit
// seven-segment scanner (seg_scan).
// Optional build macro: DISP_BLANK_LEAD_EN (leading-zero digit blanking, in
// seg_scan).
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_en       in   memory access this cycle
//   write_mem    in   1 = store, 0 = load
//   is_display   in   access targets the display register
//   addr         in   32-bit byte address; addr[1:0] ignored
//   write_data   in   32-bit store data
//   mem_data_rd  out  combinational read data (0 when idle or out of range)
//   disp_value   out  display register contents
//   seg          out  active-low segments {dp,g,f,e,d,c,b,a}
//   an           out  active-low digit enables
//   oob_err      out  sticky: a RAM access fell outside DEPTH_WORDS
// -----------------------------------------------------------------------------
module data_mem_disp
  import data_mem_disp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int SCAN_DIV    = DEFAULT_SCAN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        write_mem,
  input  logic        is_display,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] mem_data_rd,
  output logic [31:0] disp_value,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        oob_err
);

  localparam int AW = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]   ram [0:DEPTH_WORDS-1];
  logic [31:0]   disp_reg;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          ram_access;
  logic          ram_store;
  logic          disp_store;
  logic          unused_byte_offset;

  // Word index drops the byte offset; anything with bits set above the RAM
  // window is out of range rather than aliased back into it.
  assign idx                = addr[AW+1:2];
  assign in_range           = (addr[31:AW+2] == '0);
  assign unused_byte_offset = ^addr[1:0];

  assign ram_access = mem_en & ~is_display;
  assign ram_store  = ram_access & write_mem & in_range;
  assign disp_store = mem_en & write_mem & is_display;

  // RAM has no reset, so a store on the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (ram_store) begin
      ram[idx] <= write_data;
    end
  end

  // Display register: reset wins over a coinciding store.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg <= '0;
    end else if (disp_store) begin
      disp_reg <= write_data;
    end
  end

  // Sticky out-of-range flag for RAM loads and stores alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_err <= 1'b0;
    end else if (ram_access && !in_range) begin
      oob_err <= 1'b1;
    end
  end

  // Read path presents the pre-edge contents for any enabled access, so a
  // load and a store to the same word in one cycle return the old data.
  always_comb begin
    mem_data_rd = '0;
    if (mem_en) begin
      if (is_display) begin
        mem_data_rd = disp_reg;
      end else if (in_range) begin
        mem_data_rd = ram[idx];
      end
    end
  end

  assign disp_value = disp_reg;

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk      (clk),
    .rst      (rst),
    .disp_reg (disp_reg),
    .seg      (seg),
    .an       (an)
  );

endmodule

// File: tb/tb_data_mem_disp.sv
// -----------------------------------------------------------------------------
// tb_data_mem_disp
// Scoreboard bench for data_mem_disp (DEPTH_WORDS=1024, SCAN_DIV=4). The
// driver computes expected outputs from an abstract model (word map, display
// value, count of cycles since reset) and queues them; a monitor compares on
// the falling edge. Honours DISP_BLANK_LEAD_EN if defined.
// -----------------------------------------------------------------------------
module tb_data_mem_disp;

  localparam int DEPTH = 1024;
  localparam int SDIV  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        write_mem = 1'b0;
  logic        is_display = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] mem_data_rd;
  logic [31:0] disp_value;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        oob_err;

  data_mem_disp #(
    .DEPTH_WORDS (DEPTH),
    .SCAN_DIV    (SDIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .write_mem   (write_mem),
    .is_display  (is_display),
    .addr        (addr),
    .write_data  (write_data),
    .mem_data_rd (mem_data_rd),
    .disp_value  (disp_value),
    .seg         (seg),
    .an          (an),
    .oob_err     (oob_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] disp;
    logic [7:0]  an;
    logic        chk_seg;
    logic [7:0]  seg;
    logic        oob;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] disp_m;
  logic        oob_m;
  int          cyc_m;
  logic        model_known = 1'b0;
  logic [7:0]  glyph_tab [16];

  initial begin
    glyph_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then advance the model past the following clock edge.
  task automatic applyStimulus(input logic r, input logic en, input logic wr,
                               input logic dsp, input logic [31:0] a,
                               input logic [31:0] d, input string tag);
    exp_t e;
    int   digit;
    int   top;
    logic inr;
    int   wi;
    @(posedge clk);
    #1;
    rst = r; mem_en = en; write_mem = wr; is_display = dsp; addr = a; write_data = d;
    inr = (a < 32'(DEPTH * 4));
    wi  = int'(a >> 2) % DEPTH;
    if (model_known) begin
      e.tag    = tag;
      e.chk_rd = 1'b1;
      e.rd     = '0;
      if (en) begin
        if (dsp) e.rd = disp_m;
        else if (!inr) e.rd = '0;
        else if (ram_m.exists(wi)) e.rd = ram_m[wi];
        else e.chk_rd = 1'b0;
      end
      e.disp  = disp_m;
      e.oob   = oob_m;
      digit   = (cyc_m / SDIV) % 8;
      e.an    = ~(8'b1 << digit);
      e.seg   = glyph_tab[(disp_m >> (4 * digit)) & 32'hF];
      e.chk_seg = 1'b1;
`ifdef DISP_BLANK_LEAD_EN
      top = 0;
      for (int k = 0; k < 8; k++) if (((disp_m >> (4 * k)) & 32'hF) != 0) top = k;
      if (digit > top) begin
        e.an = 8'hFF;
        e.chk_seg = 1'b0;
      end
`else
      top = 7;
`endif
      exp_q.push_back(e);
    end
    if (en && wr && !dsp && inr) ram_m[wi] = d;
    if (r) begin
      disp_m = '0; oob_m = 1'b0; cyc_m = 0; model_known = 1'b1;
    end else begin
      cyc_m++;
      if (en && wr && dsp) disp_m = d;
      if (en && !dsp && !inr) oob_m = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, "idle");
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_rd) checkOutput({e.tag, ".mem_data_rd"}, mem_data_rd, e.rd);
        checkOutput({e.tag, ".disp_value"}, disp_value, e.disp);
        checkOutput({e.tag, ".an"}, {24'h0, an}, {24'h0, e.an});
        if (e.chk_seg) checkOutput({e.tag, ".seg"}, {24'h0, seg}, {24'h0, e.seg});
        checkOutput({e.tag, ".oob_err"}, {31'h0, oob_err}, {31'h0, e.oob});
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        en, wr, dsp, r;
    int          sel;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset1");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "load0_after_reset");

    // Basic store / load, byte offset ignored
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "store_10");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, "load_10");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0, "load_13");

    // Display scan over more than one full frame, aligned to reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_scan");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h12345678, "disp_store");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, "disp_load");
    idle(40);

    // Out-of-range store must not alias onto word 0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000A5A5, "store_0");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'hFFFF_FFFF, "store_oob");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, "load_oob");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "load_0_unchanged");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFC, 32'h0, "load_last_word");
    idle(3);

    // Read-during-write returns old data
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_oob_clear");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h1, "store_20_a");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h2, "rdw_20");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, "load_20_new");

    // Stores coinciding with reset
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h55, "disp_pre");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h77, "disp_store_on_rst");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h24, 32'hCAFEF00D, "ram_store_on_rst");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0, "load_24");

    // Leading-digit pattern, then reset mid-frame
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h00000A05, "disp_a05");
    idle(22);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_mid_frame");
    idle(6);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (sel == 1) a = $urandom | 32'h8000_0000;
      else               a = {22'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 3'b000} >> 1;
      en  = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1) == 1;
      dsp = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 59) == 0);
      applyStimulus(r, en, wr, dsp, a, $urandom, "rand");
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "drain");
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
